// File: rtl/decoder_5x32.sv
// Registered 5-to-32 decoder: 2-to-4 predecoder on a[4:3] gating four 3-to-8 banks on a[2:0].
// Optional macro DECODER_5X32_VALID_EN adds a registered y_valid output aligned with y.
module decoder_5x32 #(
  parameter bit OUT_ACTIVE_HIGH = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  a,
  input  logic        en,
`ifdef DECODER_5X32_VALID_EN
  output logic        y_valid,
`endif
  output logic [31:0] y
);

  localparam logic [31:0] IDLE_VALUE = OUT_ACTIVE_HIGH ? 32'h0000_0000 : 32'hFFFF_FFFF;

  // One bank of the hierarchy; a disabled bank drives all zeros regardless of sel.
  function automatic logic [7:0] dec3to8(input logic [2:0] sel, input logic bank_en);
    logic [7:0] lines;
    lines = 8'h00;
    if (bank_en) begin
      case (sel)
        3'd0:    lines = 8'h01;
        3'd1:    lines = 8'h02;
        3'd2:    lines = 8'h04;
        3'd3:    lines = 8'h08;
        3'd4:    lines = 8'h10;
        3'd5:    lines = 8'h20;
        3'd6:    lines = 8'h40;
        3'd7:    lines = 8'h80;
        default: lines = 8'h00;
      endcase
    end else begin
      lines = 8'h00;
    end
    return lines;
  endfunction

  logic [3:0]  g_s;
  logic [31:0] lines_s;
  logic [31:0] y_d;
  logic [31:0] y_q;
  logic        valid_d;
  logic        valid_q;

  // Predecoder: g_s[j] = en & (a[4:3] == j); en=0 masks any unknown address bits.
  always_comb begin
    g_s = 4'b0000;
    if (en) begin
      case (a[4:3])
        2'd0:    g_s = 4'b0001;
        2'd1:    g_s = 4'b0010;
        2'd2:    g_s = 4'b0100;
        2'd3:    g_s = 4'b1000;
        default: g_s = 4'b0000;
      endcase
    end else begin
      g_s = 4'b0000;
    end
  end

  // Four 3-to-8 banks, bank j drives lines_s[8j+7:8j].
  always_comb begin
    lines_s = 32'h0000_0000;
    for (int j = 0; j < 4; j++) begin
      lines_s[8*j +: 8] = dec3to8(a[2:0], g_s[j]);
    end
  end

  // Polarity is applied ahead of the register so y comes straight from flops.
  always_comb begin
    y_d     = 32'h0000_0000;
    valid_d = en;
    if (OUT_ACTIVE_HIGH) begin
      y_d = lines_s;
    end else begin
      y_d = ~lines_s;
    end
  end

  // Output register with synchronous active-low reset to the idle pattern.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q     <= IDLE_VALUE;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign y = y_q;

`ifdef DECODER_5X32_VALID_EN
  assign y_valid = valid_q;
`else
  logic unused_valid_s;
  assign unused_valid_s = valid_q;
`endif

endmodule

// File: tb/tb_decoder_5x32.sv
// Directed bench for decoder_5x32: one active-high and one active-low instance share stimulus.
// Checks y_valid as well when DECODER_5X32_VALID_EN is defined.
module tb_decoder_5x32;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [4:0]  a;
  logic [31:0] y_hi;
  logic [31:0] y_lo;
`ifdef DECODER_5X32_VALID_EN
  logic        y_valid_hi;
  logic        y_valid_lo;
`endif

  int checks = 0;
  int errors = 0;

  decoder_5x32 #(.OUT_ACTIVE_HIGH(1'b1)) dut_hi (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .en      (en),
`ifdef DECODER_5X32_VALID_EN
    .y_valid (y_valid_hi),
`endif
    .y       (y_hi)
  );

  decoder_5x32 #(.OUT_ACTIVE_HIGH(1'b0)) dut_lo (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .en      (en),
`ifdef DECODER_5X32_VALID_EN
    .y_valid (y_valid_lo),
`endif
    .y       (y_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [4:0]  a;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_valid;
    string       name;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs away from the edge, clock once, sample 1 time unit after the edge.
  task automatic apply(input logic r, input logic e, input logic [4:0] addr);
    @(negedge clk);
    rst_n = r;
    en    = e;
    a     = addr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_valid(input string name, input logic exp);
`ifdef DECODER_5X32_VALID_EN
    check({name, "_valid_hi"}, {31'd0, y_valid_hi}, {31'd0, exp});
    check({name, "_valid_lo"}, {31'd0, y_valid_lo}, {31'd0, exp});
`else
    if (exp === 1'bx) $display("unused %s", name);
`endif
  endtask

  initial begin
    logic [31:0] one_hot;

    vecs[0] = '{1'b0, 1'b1, 5'd27,   32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "reset_a"};
    vecs[1] = '{1'b0, 1'b1, 5'd27,   32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "reset_b"};
    vecs[2] = '{1'b1, 1'b1, 5'd27,   32'h0800_0000, 32'hF7FF_FFFF, 1'b1, "basic_27"};
    vecs[3] = '{1'b1, 1'b0, 5'd27,   32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "disable_27"};
    vecs[4] = '{1'b1, 1'b1, 5'd27,   32'h0800_0000, 32'hF7FF_FFFF, 1'b1, "reenable_27"};
    vecs[5] = '{1'b1, 1'b0, 5'bxxxxx, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "x_addr_disabled"};
    vecs[6] = '{1'b1, 1'b1, 5'd8,    32'h0000_0100, 32'hFFFF_FEFF, 1'b1, "addr_8"};
    vecs[7] = '{1'b1, 1'b0, 5'd8,    32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "disable_8"};
    vecs[8] = '{1'b0, 1'b1, 5'd8,    32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "reset_again"};

    rst_n = 1'b0;
    en    = 1'b0;
    a     = 5'd0;

    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].rst_n, vecs[i].en, vecs[i].a);
      check({vecs[i].name, "_hi"}, y_hi, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"}, y_lo, vecs[i].exp_lo);
      check_valid(vecs[i].name, vecs[i].exp_valid);
    end

    // Full sweep, address changing every edge.
    for (int i = 0; i < 32; i++) begin
      apply(1'b1, 1'b1, i[4:0]);
      one_hot = 32'h0000_0001 << i;
      check($sformatf("sweep_hi_%0d", i), y_hi, one_hot);
      check($sformatf("sweep_lo_%0d", i), y_lo, ~one_hot);
      check($sformatf("sweep_onehot_%0d", i), $countones(y_hi), 32'd1);
      check_valid($sformatf("sweep_%0d", i), 1'b1);
    end
    check("sweep_last_hi", y_hi, 32'h8000_0000);

    // Reset asserted mid-sweep, released on the next address.
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'b1, i[4:0]);
    end
    check("pre_reset_a4", y_hi, 32'h0000_0010);
    apply(1'b0, 1'b1, 5'd5);
    check("midreset_hi", y_hi, 32'h0000_0000);
    check("midreset_lo", y_lo, 32'hFFFF_FFFF);
    check_valid("midreset", 1'b0);
    apply(1'b1, 1'b1, 5'd6);
    check("release_a6_hi", y_hi, 32'h0000_0040);
    check("release_a6_lo", y_lo, 32'hFFFF_FFBF);
    check_valid("release_a6", 1'b1);

    // Output must hold across an edge-free interval: inputs change but no edge yet.
    @(negedge clk);
    a  = 5'd31;
    en = 1'b1;
    #2;
    check("no_comb_path_hi", y_hi, 32'h0000_0040);
    @(posedge clk);
    #1;
    check("a31_hi", y_hi, 32'h8000_0000);
    check("a31_lo", y_lo, 32'h7FFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
